// File: rtl/cache_pkg.sv
// Shared definitions for the cache-to-memory arbiter: line geometry defaults,
// FSM state encoding and requester identifiers.
package cache_pkg;

    localparam int LINE_WORDS = 4;
    localparam int IDX_W      = $clog2(LINE_WORDS);
    localparam int OFF        = IDX_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Requester identifiers double as bit positions in the arbiter request vector.
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and main-memory signals around the arbiter.
// Handshake: a requester holds req until it sees done; the arbiter owns the
// memory port while gnt is high, and each word completes on a cycle with
// mem_cs=1 and mem_ack=1 (mem_ack low inserts wait states, unbounded).
interface cache_mem_arbiter_if
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) ();

    localparam int IW = $clog2(LINE_WORDS);

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic [IW-1:0]     i_idx;
    logic              i_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic [IW-1:0]     d_idx;
    logic              d_done;

    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    arb_state_t        dbg_state;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata, i_idx, i_done,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_idx, d_done,
        output mem_cs, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output dbg_state
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata, i_idx, i_done,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_idx, d_done,
        input  mem_cs, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  dbg_state
    );

endinterface

// File: rtl/cache_mem_arbiter_rr.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not served last.
module rr_arbiter2
    import cache_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_i == REQ_I) ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between I-cache refills and D-cache refills or
// write-backs, sequencing a full line burst per grant.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = cache_pkg::LINE_WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_mem_arbiter_if.slave   bus
);

    localparam int IW = $clog2(LINE_WORDS);
    localparam int OW = IW + 2;
    localparam logic [IW-1:0] LAST_IDX = IW'(LINE_WORDS - 1);

    arb_state_t             state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   last_q,  last_d;
    logic                   we_q,    we_d;
    logic [ADDR_W-OW-1:0]   line_q,  line_d;
    logic [IW-1:0]          idx_q,   idx_d;
    logic [IW-1:0]          ridx_q,  ridx_d;
    logic                   rvalid_q, rvalid_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;

    logic [1:0]             req_vec;
    logic [1:0]             pick;
    logic                   xfer;
    logic                   busy;
    logic                   word_ack;
    logic                   own_i;
    logic                   own_d;
    logic [IW-1:0]          idx_out;

    assign req_vec = {bus.d_req, bus.i_req};

    rr_arbiter2 u_rr (
        .req_i   (req_vec),
        .last_i  (last_q),
        .grant_o (pick)
    );

    assign xfer     = (state_q == XFER);
    assign busy     = (state_q != IDLE);
    assign word_ack = xfer && bus.mem_ack;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        line_d  = line_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (pick != 2'b00) begin
                    owner_d = pick[REQ_D] ? REQ_D : REQ_I;
                    line_d  = pick[REQ_D] ? bus.d_addr[ADDR_W-1:OW]
                                          : bus.i_addr[ADDR_W-1:OW];
                    we_d    = pick[REQ_D] && bus.d_we;
                    idx_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (bus.mem_ack) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read return lags the acknowledged word by one cycle, so its index is
    // captured separately from the live word counter.
    always_comb begin
        rvalid_d = word_ack && !we_q;
        ridx_d   = word_ack ? idx_q : ridx_q;
        rdata_d  = (word_ack && !we_q) ? bus.mem_rdata : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= REQ_I;
            last_q   <= REQ_I;
            we_q     <= 1'b0;
            line_q   <= '0;
            idx_q    <= '0;
            ridx_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            line_q   <= line_d;
            idx_q    <= idx_d;
            ridx_q   <= ridx_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign own_i   = busy && (owner_q == REQ_I);
    assign own_d   = busy && (owner_q == REQ_D);
    assign idx_out = rvalid_q ? ridx_q : idx_q;

    assign bus.i_gnt    = own_i;
    assign bus.i_rvalid = own_i && rvalid_q;
    assign bus.i_rdata  = own_i ? rdata_q : '0;
    assign bus.i_idx    = own_i ? idx_out : '0;
    assign bus.i_done   = own_i && (state_q == DONE);

    assign bus.d_gnt    = own_d;
    assign bus.d_rvalid = own_d && rvalid_q;
    assign bus.d_rdata  = own_d ? rdata_q : '0;
    assign bus.d_idx    = own_d ? idx_out : '0;
    assign bus.d_done   = own_d && (state_q == DONE);

    // Write data is a combinational pass-through; the D-cache drives the word
    // that d_idx selects in the same cycle.
    assign bus.mem_cs    = xfer;
    assign bus.mem_we    = xfer && own_d && we_q;
    assign bus.mem_addr  = xfer ? {line_q, idx_q, 2'b00} : '0;
    assign bus.mem_wdata = xfer ? bus.d_wdata : '0;

    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: memory and cache models around the DUT, a
// negedge monitor logging bus events, and per-scenario tasks checking the log
// against bursts predicted from the arbitration rules.
module tb_cache_mem_arbiter;
    import cache_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int IW = 2;

    typedef logic [AW+DW:0] rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) bus ();

    cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] mem_key = 32'h0;
    logic [DW-1:0] d_line [LW];
    int            ack_mode = 0;
    int            wait_cnt = 0;
    logic          model_last = REQ_I;

    assign bus.mem_rdata = bus.mem_addr ^ mem_key;
    assign bus.d_wdata   = d_line[bus.d_idx];

    // Memory acknowledge: 0 = every cycle, 1 = every third cs cycle, 2 = random.
    always @(posedge clk) begin
        #1;
        if (!bus.mem_cs) wait_cnt = 0;
        else             wait_cnt++;
        case (ack_mode)
            0:       bus.mem_ack = 1'b1;
            1:       bus.mem_ack = (wait_cnt > 0) && (wait_cnt % 3 == 0);
            default: bus.mem_ack = ($urandom_range(0, 1) == 1);
        endcase
    end

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rec_t acc_q[$], iret_q[$], dret_q[$], gnt_q[$];
    int   iret_cyc_q[$], done_cyc_q[$], gnt_cyc_q[$];
    logic done_id_q[$];
    int   viol = 0;
    int   cs_cycles = 0;
    logic prev_ig = 1'b0;
    logic prev_dg = 1'b0;

    rec_t exp_acc_q[$], exp_iret_q[$], exp_dret_q[$], exp_gnt_q[$];

    always @(negedge clk) begin
        if (bus.mem_cs) cs_cycles++;
        if (bus.mem_cs && bus.mem_ack)
            acc_q.push_back({bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 32'h0});
        if (bus.i_rvalid) begin
            iret_q.push_back(rec_t'({bus.i_idx, bus.i_rdata}));
            iret_cyc_q.push_back(cyc);
        end
        if (bus.d_rvalid) dret_q.push_back(rec_t'({bus.d_idx, bus.d_rdata}));
        if (bus.i_done) begin done_id_q.push_back(REQ_I); done_cyc_q.push_back(cyc); end
        if (bus.d_done) begin done_id_q.push_back(REQ_D); done_cyc_q.push_back(cyc); end
        if (bus.i_gnt && !prev_ig) begin gnt_q.push_back(rec_t'(REQ_I)); gnt_cyc_q.push_back(cyc); end
        if (bus.d_gnt && !prev_dg) begin gnt_q.push_back(rec_t'(REQ_D)); gnt_cyc_q.push_back(cyc); end
        prev_ig = bus.i_gnt;
        prev_dg = bus.d_gnt;
        if (bus.i_gnt === 1'b1 && bus.d_gnt === 1'b1) viol++;
        if (bus.mem_cs === 1'b1 && !(bus.i_gnt || bus.d_gnt)) viol++;
        if ((bus.i_rvalid || bus.i_done) && !bus.i_gnt) viol++;
        if ((bus.d_rvalid || bus.d_done) && !bus.d_gnt) viol++;
    end

    function automatic int q_diff(input rec_t a[$], input rec_t b[$]);
        int n = (a.size() > b.size()) ? a.size() : b.size();
        for (int k = 0; k < n; k++)
            if (k >= a.size() || k >= b.size() || a[k] !== b[k]) return k;
        return -1;
    endfunction

    function automatic rec_t q_at(input rec_t a[$], input int i);
        return (i >= 0 && i < a.size()) ? a[i] : 'x;
    endfunction

    function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] line, input int k);
        return (line & ~AW'(LW * 4 - 1)) + AW'(4 * k);
    endfunction

    task automatic clear_logs();
        acc_q.delete(); iret_q.delete(); dret_q.delete(); gnt_q.delete();
        iret_cyc_q.delete(); done_cyc_q.delete(); gnt_cyc_q.delete(); done_id_q.delete();
        exp_acc_q.delete(); exp_iret_q.delete(); exp_dret_q.delete(); exp_gnt_q.delete();
        viol = 0;
        cs_cycles = 0;
    endtask

    // Reference burst: every word of the line in order, reads echo addr^key.
    task automatic expect_burst(input logic id, input logic [AW-1:0] a, input logic we);
        for (int k = 0; k < LW; k++) begin
            exp_acc_q.push_back({we, word_addr(a, k), we ? d_line[k] : 32'h0});
            if (!we && id == REQ_I) exp_iret_q.push_back(rec_t'({IW'(k), word_addr(a, k) ^ mem_key}));
            if (!we && id == REQ_D) exp_dret_q.push_back(rec_t'({IW'(k), word_addr(a, k) ^ mem_key}));
        end
        exp_gnt_q.push_back(rec_t'(id));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        model_last = REQ_I;
        clear_logs();
    endtask

    // Plays the cache side: drops req on its done (or both after n dones when held).
    task automatic serve(input int n, input bit hold, output bit ok);
        int base = done_id_q.size();
        int seen = 0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            while (base + seen < done_id_q.size()) begin
                if (hold) begin
                    if (seen + 1 >= n) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
                end else if (done_id_q[base + seen] == REQ_I) bus.i_req = 1'b0;
                else bus.d_req = 1'b0;
                seen++;
            end
            if (seen >= n) begin ok = 1'b1; break; end
        end
        if (!ok) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] ctrl;
        rst = 1'b0; ack_mode = 0;
        bus.i_req = 1'b1; bus.d_req = 1'b1; bus.i_addr = 32'h40; bus.d_addr = 32'h80;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ctrl = {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done, bus.mem_cs, bus.mem_we};
        tests_run++;
        if (ctrl !== 8'h00) begin tests_failed++; $display("FAIL reset_ctrl: got %b expected 00000000", ctrl); end
        tests_run++;
        if (bus.mem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0", bus.mem_addr); end
        tests_run++;
        if ({bus.i_idx, bus.d_idx, bus.i_rdata, bus.d_rdata} !== '0) begin
            tests_failed++; $display("FAIL reset_data: got %h/%h idx %0d/%0d expected all 0", bus.i_rdata, bus.d_rdata, bus.i_idx, bus.d_idx);
        end
        tests_run++;
        if (bus.dbg_state !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, IDLE); end
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (cs_cycles !== 0 || gnt_q.size() !== 0) begin
            tests_failed++; $display("FAIL idle_quiet: got cs %0d grants %0d expected 0/0", cs_cycles, gnt_q.size());
        end
    endtask

    task automatic test_i_read();
        int start; bit ok; int d;
        do_reset();
        ack_mode = 0; mem_key = $urandom;
        expect_burst(REQ_I, 32'h104, 1'b0);
        @(posedge clk); #1;
        bus.i_addr = 32'h104; bus.i_req = 1'b1; start = cyc;
        serve(1, 1'b0, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL i_read_timeout: got %0d dones expected 1", done_id_q.size()); end
        tests_run++;
        if (gnt_cyc_q.size() != 1 || gnt_cyc_q[0] - start !== 1) begin
            tests_failed++; $display("FAIL i_read_gnt_lat: got %0d grants lat %0d expected 1 lat 1", gnt_cyc_q.size(), gnt_cyc_q.size() ? gnt_cyc_q[0] - start : -1);
        end
        tests_run++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] - start !== LW + 1) begin
            tests_failed++; $display("FAIL i_read_done_lat: got %0d dones lat %0d expected 1 lat %0d", done_cyc_q.size(), done_cyc_q.size() ? done_cyc_q[0] - start : -1, LW + 1);
        end
        tests_run++; d = q_diff(acc_q, exp_acc_q);
        if (d !== -1) begin tests_failed++; $display("FAIL i_read_acc[%0d]: got %h expected %h", d, q_at(acc_q, d), q_at(exp_acc_q, d)); end
        tests_run++; d = q_diff(iret_q, exp_iret_q);
        if (d !== -1) begin tests_failed++; $display("FAIL i_read_ret[%0d]: got %h expected %h", d, q_at(iret_q, d), q_at(exp_iret_q, d)); end
        tests_run++;
        if (iret_cyc_q.size() == 0 || done_cyc_q.size() == 0 || iret_cyc_q[iret_cyc_q.size()-1] !== done_cyc_q[0]) begin
            tests_failed++; $display("FAIL i_read_last_rvalid: got cycle %0d expected done cycle %0d",
                iret_cyc_q.size() ? iret_cyc_q[iret_cyc_q.size()-1] : -1, done_cyc_q.size() ? done_cyc_q[0] : -1);
        end
        tests_run++;
        if (dret_q.size() !== 0 || viol !== 0) begin
            tests_failed++; $display("FAIL i_read_isolation: got d_rvalid %0d violations %0d expected 0/0", dret_q.size(), viol);
        end
    endtask

    task automatic test_tie();
        bit ok; int d; logic [AW-1:0] ia, da;
        do_reset();
        ack_mode = 0; mem_key = $urandom; ia = $urandom; da = $urandom;
        expect_burst(REQ_D, da, 1'b0);
        expect_burst(REQ_I, ia, 1'b0);
        expect_burst(REQ_D, da, 1'b0);
        @(posedge clk); #1;
        bus.i_addr = ia; bus.d_addr = da; bus.d_we = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        serve(1, 1'b0, ok);
        bus.d_req = 1'b1;
        if (ok) serve(2, 1'b0, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL tie_timeout: got %0d dones expected 3", done_id_q.size()); end
        tests_run++; d = q_diff(gnt_q, exp_gnt_q);
        if (d !== -1) begin tests_failed++; $display("FAIL tie_order[%0d]: got %0d expected %0d", d, q_at(gnt_q, d), q_at(exp_gnt_q, d)); end
        tests_run++; d = q_diff(acc_q, exp_acc_q);
        if (d !== -1) begin tests_failed++; $display("FAIL tie_acc[%0d]: got %h expected %h", d, q_at(acc_q, d), q_at(exp_acc_q, d)); end
        tests_run++;
        if (q_diff(iret_q, exp_iret_q) !== -1 || q_diff(dret_q, exp_dret_q) !== -1 || viol !== 0) begin
            tests_failed++; $display("FAIL tie_ret: got i %0d d %0d words viol %0d expected %0d %0d 0", iret_q.size(), dret_q.size(), viol, exp_iret_q.size(), exp_dret_q.size());
        end
    endtask

    task automatic test_d_write();
        bit ok; int d; logic [AW-1:0] da;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            clear_logs();
            ack_mode = (pass == 0) ? 0 : 2;
            da = (pass == 0) ? 32'h200 : $urandom;
            for (int k = 0; k < LW; k++) d_line[k] = (pass == 0) ? 32'hA0 + k : $urandom;
            expect_burst(REQ_D, da, 1'b1);
            @(posedge clk); #1;
            bus.d_addr = da; bus.d_we = 1'b1; bus.d_req = 1'b1;
            serve(1, 1'b0, ok);
            bus.d_we = 1'b0;
            tests_run++;
            if (!ok || done_id_q.size() !== 1) begin
                tests_failed++; $display("FAIL d_write_done: got %0d dones expected 1", done_id_q.size());
            end
            tests_run++; d = q_diff(acc_q, exp_acc_q);
            if (d !== -1) begin tests_failed++; $display("FAIL d_write_acc[%0d]: got %h expected %h", d, q_at(acc_q, d), q_at(exp_acc_q, d)); end
            tests_run++;
            if (dret_q.size() !== 0 || iret_q.size() !== 0 || viol !== 0) begin
                tests_failed++; $display("FAIL d_write_no_rvalid: got d %0d i %0d viol %0d expected 0 0 0", dret_q.size(), iret_q.size(), viol);
            end
        end
    endtask

    task automatic test_wait_states();
        int start; bit ok; int d; logic [AW-1:0] ia;
        do_reset();
        ack_mode = 1; mem_key = $urandom; ia = $urandom;
        expect_burst(REQ_I, ia, 1'b0);
        @(posedge clk); #1;
        bus.i_addr = ia; bus.i_req = 1'b1; start = cyc;
        serve(1, 1'b0, ok);
        tests_run++;
        if (!ok || cs_cycles !== 3 * LW) begin
            tests_failed++; $display("FAIL wait_xfer_len: got %0d cs cycles expected %0d", cs_cycles, 3 * LW);
        end
        tests_run++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] - start !== 3 * LW + 1) begin
            tests_failed++; $display("FAIL wait_done_lat: got %0d expected %0d", done_cyc_q.size() ? done_cyc_q[0] - start : -1, 3 * LW + 1);
        end
        tests_run++; d = q_diff(acc_q, exp_acc_q);
        if (d !== -1) begin tests_failed++; $display("FAIL wait_acc[%0d]: got %h expected %h", d, q_at(acc_q, d), q_at(exp_acc_q, d)); end
        tests_run++; d = q_diff(iret_q, exp_iret_q);
        if (d !== -1) begin tests_failed++; $display("FAIL wait_ret[%0d]: got %h expected %h", d, q_at(iret_q, d), q_at(exp_iret_q, d)); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok; bit seen2 = 1'b0; int d; logic [7:0] ctrl; logic [AW-1:0] ia;
        do_reset();
        ack_mode = 0; mem_key = $urandom; ia = $urandom;
        @(posedge clk); #1;
        bus.i_addr = ia; bus.i_req = 1'b1;
        for (int c = 0; c < 20 && !seen2; c++) begin
            @(negedge clk); #1;
            if (acc_q.size() >= 2) seen2 = 1'b1;
        end
        rst = 1'b0; bus.i_req = 1'b0;
        @(negedge clk);
        ctrl = {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done, bus.mem_cs, bus.mem_we};
        tests_run++;
        if (!seen2 || ctrl !== 8'h00 || bus.mem_addr !== 32'h0) begin
            tests_failed++; $display("FAIL abort_outputs: got ctrl %b addr %h expected 0/0", ctrl, bus.mem_addr);
        end
        tests_run++;
        if (done_id_q.size() !== 0 || iret_q.size() !== 1) begin
            tests_failed++; $display("FAIL abort_no_done: got %0d dones %0d words expected 0 dones 1 word", done_id_q.size(), iret_q.size());
        end
        #1;
        rst = 1'b1;
        clear_logs();
        ia = $urandom;
        expect_burst(REQ_I, ia, 1'b0);
        @(posedge clk); #1;
        bus.i_addr = ia; bus.i_req = 1'b1;
        serve(1, 1'b0, ok);
        tests_run++; d = q_diff(acc_q, exp_acc_q);
        if (!ok || d !== -1) begin tests_failed++; $display("FAIL abort_restart_acc[%0d]: got %h expected %h", d, q_at(acc_q, d), q_at(exp_acc_q, d)); end
        tests_run++; d = q_diff(iret_q, exp_iret_q);
        if (d !== -1) begin tests_failed++; $display("FAIL abort_restart_ret[%0d]: got %h expected %h", d, q_at(iret_q, d), q_at(exp_iret_q, d)); end
    endtask

    task automatic test_starvation();
        bit ok; int d; logic [AW-1:0] ia, da;
        do_reset();
        ack_mode = 2; mem_key = $urandom; ia = $urandom; da = $urandom;
        for (int n = 0; n < 6; n++) begin
            if (n % 2 == 0) expect_burst(REQ_D, da, 1'b0);
            else            expect_burst(REQ_I, ia, 1'b0);
        end
        @(posedge clk); #1;
        bus.i_addr = ia; bus.d_addr = da; bus.d_we = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        serve(6, 1'b1, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL starve_timeout: got %0d dones expected 6", done_id_q.size()); end
        tests_run++; d = q_diff(gnt_q, exp_gnt_q);
        if (d !== -1) begin tests_failed++; $display("FAIL starve_order[%0d]: got %0d expected %0d", d, q_at(gnt_q, d), q_at(exp_gnt_q, d)); end
        tests_run++; d = q_diff(acc_q, exp_acc_q);
        if (d !== -1) begin tests_failed++; $display("FAIL starve_acc[%0d]: got %h expected %h", d, q_at(acc_q, d), q_at(exp_acc_q, d)); end
        tests_run++;
        if (q_diff(iret_q, exp_iret_q) !== -1 || q_diff(dret_q, exp_dret_q) !== -1 || viol !== 0) begin
            tests_failed++; $display("FAIL starve_ret: got i %0d d %0d viol %0d expected %0d %0d 0", iret_q.size(), dret_q.size(), viol, exp_iret_q.size(), exp_dret_q.size());
        end
    endtask

    task automatic test_random();
        bit ok; int d; int pat; int n; logic first; logic we; logic [AW-1:0] ia, da;
        do_reset();
        for (int it = 0; it < 12; it++) begin
            clear_logs();
            pat = $urandom_range(1, 3);
            ack_mode = $urandom_range(0, 1) * 2;
            mem_key = $urandom; ia = $urandom; da = $urandom;
            we = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < LW; k++) d_line[k] = $urandom;
            if (pat == 3) first = (model_last == REQ_I) ? REQ_D : REQ_I;
            else          first = (pat == 2) ? REQ_D : REQ_I;
            expect_burst(first, (first == REQ_D) ? da : ia, (first == REQ_D) && we);
            model_last = first;
            n = 1;
            if (pat == 3) begin
                expect_burst(~first, (~first == REQ_D) ? da : ia, (~first == REQ_D) && we);
                model_last = ~first;
                n = 2;
            end
            @(posedge clk); #1;
            bus.i_addr = ia; bus.d_addr = da; bus.d_we = we;
            bus.i_req = (pat != 2); bus.d_req = (pat != 1);
            serve(n, 1'b0, ok);
            tests_run++; d = q_diff(gnt_q, exp_gnt_q);
            if (!ok || d !== -1) begin
                tests_failed++; $display("FAIL rand%0d_order[%0d]: got %0d expected %0d (dones %0d)", it, d, q_at(gnt_q, d), q_at(exp_gnt_q, d), done_id_q.size());
            end
            tests_run++; d = q_diff(acc_q, exp_acc_q);
            if (d !== -1) begin tests_failed++; $display("FAIL rand%0d_acc[%0d]: got %h expected %h", it, d, q_at(acc_q, d), q_at(exp_acc_q, d)); end
            tests_run++;
            if (q_diff(iret_q, exp_iret_q) !== -1 || q_diff(dret_q, exp_dret_q) !== -1 || viol !== 0) begin
                tests_failed++; $display("FAIL rand%0d_ret: got i %0d d %0d viol %0d expected %0d %0d 0", it, iret_q.size(), dret_q.size(), viol, exp_iret_q.size(), exp_dret_q.size());
            end
        end
    endtask

    initial begin
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
        for (int k = 0; k < LW; k++) d_line[k] = '0;
        test_reset();
        test_i_read();
        test_tie();
        test_d_write();
        test_wait_states();
        test_reset_mid_burst();
        test_starvation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single main-memory port between the I-cache refill path and the D-cache refill/write-back path of the pipelined CPU.
- Grants one requester at a time and sequences a full cache-line burst, one word per memory acknowledge.
- Returns read data and a completion pulse to the granted cache.
- Sits between the two cache controllers and the memory model inside top.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, memory word width
- LINE_WORDS, 4, words per cache line (power of 2, at least 2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-low reset
- i_req  in  1  I-cache line-read request, level
- i_addr  in  ADDR_W  I-cache line address; offset bits ignored
- i_gnt  out  1  I-cache owns the memory port
- i_rvalid  out  1  one read word valid for I-cache
- i_rdata  out  DATA_W  read word for I-cache
- i_idx  out  log2(LINE_WORDS)  index of the current word in the line
- i_done  out  1  one-cycle end-of-burst pulse
- d_req  in  1  D-cache request, level
- d_we  in  1  1 = line write-back, 0 = line read
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  DATA_W  write word, selected by d_idx
- d_gnt, d_rvalid, d_rdata, d_idx, d_done  out  as for the I-cache port
- mem_cs  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word byte-address
- mem_wdata  out  DATA_W  write data, passed through from d_wdata
- mem_rdata  in  DATA_W  memory read data
- mem_ack  in  1  current word accepted or returned this cycle

Behaviour:
- Reset: when rst=0 at a rising clk edge, all outputs go to 0, the FSM goes to IDLE, the word counter goes to 0, and last_grant is set to I. The first tie after reset therefore goes to D.
- FSM states are IDLE, XFER and DONE.
- IDLE:
  - Requests are sampled here only.
  - If exactly one of i_req/d_req is high, that requester wins.
  - If both are high, the requester that was not last_grant wins (2-way round-robin).
  - The winner's gnt, its latched address and we, and mem_cs are registered at the next edge. The FSM then enters XFER with idx=0.
  - Latency is 1 cycle from req to gnt and mem_cs.
- XFER:
  - mem_cs=1.
  - mem_we = latched d_we when D owns the port, else 0.
  - mem_addr = {latched_addr[ADDR_W-1:OFF], idx, 2'b00}, where OFF = log2(LINE_WORDS)+2.
  - mem_wdata = d_wdata combinationally. The D-cache must drive the word selected by d_idx in the same cycle.
  - On mem_ack=1, idx increments.
  - On mem_ack=1 with idx=LINE_WORDS-1, idx wraps to 0 and the FSM goes to DONE.
  - mem_ack=0 holds everything unchanged (wait states are unbounded).
- Read return: on each acked read word, the owner's rvalid is pulsed high for 1 cycle at the next edge, with rdata = registered mem_rdata and idx equal to the index of that word.
- DONE:
  - mem_cs=0.
  - The owner's done=1 for exactly 1 cycle and its gnt stays 1.
  - The last rvalid coincides with done.
  - last_grant is updated, then the FSM returns to IDLE with gnt=0.
- Requesters must drop req in the cycle after done. A req still high in IDLE starts a new burst.
- Dropping req during XFER has no effect: the burst always completes.
- mem_ack while in IDLE or DONE is ignored.
- The non-owner's gnt, rvalid and done stay 0 throughout.
- Reset mid-burst: abort immediately, with no done pulse. Memory sees mem_cs=0 the next cycle.
- Minimum burst length is LINE_WORDS+2 cycles from req.

Decomposition:
- Shared package cache_pkg holds:
  - LINE_WORDS and the OFF/IDX_W localparams
  - the arb_state_t encoding (IDLE=2'd0, XFER=2'd1, DONE=2'd2)
  - the requester ID constants REQ_I=0 and REQ_D=1
- Sub-module rr_arbiter2: combinational 2-way round-robin pick (req[1:0], last -> grant[1:0]). It is reusable for a future write buffer.

Test Plan:
1. I-only read: i_req=1, i_addr=0x104, mem_ack tied 1 -> i_gnt at cycle 1; mem_addr 0x100, 0x104, 0x108, 0x10C on consecutive cycles; 4 i_rvalid with i_idx 0..3; i_done one cycle later.
2. Simultaneous request right after reset: i_req=d_req=1 -> D granted first. After d_done, I granted; then D again if it re-requests.
3. D write-back at 0x200, d_wdata = 0xA0+idx -> mem_we=1 on all 4 words; mem_wdata 0xA0..0xA3 in order; no d_rvalid; d_done once.
4. Wait states: mem_ack high every 3rd cycle -> mem_addr holds for 3 cycles per word; idx advances only on ack; burst takes 12 cycles in XFER.
5. Reset mid-burst: rst=0 after the 2nd ack -> next cycle all outputs are 0. After rst=1 and a new i_req, the burst restarts at idx 0.
6. Starvation check: d_req held high continuously with i_req high -> grants alternate D, I, D, I; no requester served twice while the other waits.
